// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA-3 round controller.
package sha3_pkg;

  localparam int Z_WIDTH        = 64;
  localparam int NUM_ROUNDS_DEF = 24;

  typedef logic [4:0] round_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROUND   = 2'd1,
    SQUEEZE = 2'd2
  } sha3_ctrl_state_e;

  // Legal configuration: the round index fits 5 bits and the unroll factor divides the round count.
  function automatic bit round_cfg_ok(input int num_rounds, input int rounds_per_cycle);
    return (rounds_per_cycle > 0) && (num_rounds <= 32) && (num_rounds >= rounds_per_cycle) &&
           ((num_rounds % rounds_per_cycle) == 0);
  endfunction

endpackage

// File: rtl/sha3_round_counter.sv
// Round-index counter: steps by ROUNDS_PER_CYCLE, flags the last step and returns to zero after it.
module sha3_round_counter
  import sha3_pkg::*;
#(
  parameter int NUM_ROUNDS       = NUM_ROUNDS_DEF,
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       step_i,
  output round_idx_t idx_o,
  output logic       term_o
);

  localparam round_idx_t STEP     = round_idx_t'(ROUNDS_PER_CYCLE);
  localparam round_idx_t LAST_IDX = round_idx_t'(NUM_ROUNDS - ROUNDS_PER_CYCLE);

  round_idx_t idx_d;
  round_idx_t idx_q;

  assign term_o = (idx_q == LAST_IDX);
  assign idx_o  = idx_q;

  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = 5'd0;
    end else if (step_i) begin
      idx_d = term_o ? 5'd0 : idx_q + STEP;
    end else begin
      idx_d = idx_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q <= 5'd0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/sha3_round_controller.sv
// Keccak-f[1600] sequencing FSM: block absorb handshake, round stepping, digest handshake.
// Optional clock-enable input is built when SHA3_ROUND_CE_EN is defined.
module sha3_round_controller
  import sha3_pkg::*;
#(
  parameter int NUM_ROUNDS       = NUM_ROUNDS_DEF,
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
`ifdef SHA3_ROUND_CE_EN
  input  logic       ce_i,
`endif
  input  logic       block_valid_i,
  input  logic       block_last_i,
  output logic       block_ready_o,
  output logic       absorb_en_o,
  output logic       state_clr_o,
  output logic       round_en_o,
  output round_idx_t round_idx_o,
  output logic       round_last_o,
  output logic       hash_valid_o,
  input  logic       hash_ready_i,
  output logic       busy_o
);

  if (!round_cfg_ok(NUM_ROUNDS, ROUNDS_PER_CYCLE)) begin : g_bad_cfg
    $error("sha3_round_controller: NUM_ROUNDS must be <= 32 and divisible by ROUNDS_PER_CYCLE");
  end

  sha3_ctrl_state_e state_q, state_d;
  logic             last_q, last_d;
  logic             first_q, first_d;
  logic             ce_s;
  logic             handshake_s;
  logic             step_s;
  logic             term_s;
  round_idx_t       idx_s;

`ifdef SHA3_ROUND_CE_EN
  assign ce_s = ce_i;
`else
  assign ce_s = 1'b1;
`endif

  assign handshake_s = !rst_i && ce_s && (state_q == IDLE) && block_valid_i;
  assign step_s      = !rst_i && ce_s && (state_q == ROUND);
  assign round_idx_o = rst_i ? 5'd0 : idx_s;

  sha3_round_counter #(
    .NUM_ROUNDS       (NUM_ROUNDS),
    .ROUNDS_PER_CYCLE (ROUNDS_PER_CYCLE)
  ) u_round_counter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (handshake_s),
    .step_i (step_s),
    .idx_o  (idx_s),
    .term_o (term_s)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      first_q <= first_d;
    end
  end

  // With the clock enable low every register holds its value.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    first_d = first_q;
    if (ce_s) begin
      case (state_q)
        IDLE: begin
          if (block_valid_i) begin
            state_d = ROUND;
            last_d  = block_last_i;
            first_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
        ROUND: begin
          if (term_s) begin
            state_d = last_q ? SQUEEZE : IDLE;
          end else begin
            state_d = ROUND;
          end
        end
        SQUEEZE: begin
          if (hash_ready_i) begin
            state_d = IDLE;
            first_d = 1'b1;
            last_d  = 1'b0;
          end else begin
            state_d = SQUEEZE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_comb begin
    block_ready_o = 1'b0;
    absorb_en_o   = 1'b0;
    state_clr_o   = 1'b0;
    round_en_o    = 1'b0;
    round_last_o  = 1'b0;
    hash_valid_o  = 1'b0;
    busy_o        = 1'b0;
    if (rst_i) begin
      busy_o = 1'b0;
    end else begin
      busy_o = (state_q != IDLE);
      if (ce_s) begin
        case (state_q)
          IDLE: begin
            block_ready_o = 1'b1;
            absorb_en_o   = block_valid_i;
            state_clr_o   = block_valid_i && first_q;
          end
          ROUND: begin
            round_en_o   = 1'b1;
            round_last_o = term_s;
          end
          SQUEEZE: begin
            hash_valid_o = 1'b1;
          end
          default: begin
            block_ready_o = 1'b0;
          end
        endcase
      end else begin
        block_ready_o = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sha3_round_controller.sv
// Directed bench with a round/digest scoreboard for sha3_round_controller (plus a 4-rounds-per-cycle instance).
module tb_sha3_round_controller;

  localparam int NR = 24;

  typedef struct {
    logic [4:0] idx;
    logic       last;
  } rnd_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce  = 1'b1;
  logic       block_valid = 1'b0;
  logic       block_last  = 1'b0;
  logic       hash_ready  = 1'b0;

  logic       block_ready, absorb_en, state_clr, round_en, round_last, hash_valid, busy;
  logic [4:0] round_idx;
  logic       ready4, absorb4, clr4, ren4, rlast4, hv4, busy4;
  logic [4:0] idx4;

  int   n_checks = 0;
  int   n_errors = 0;
  rnd_t exp_q[$];
  int   hash_q[$];
  int   msg_id = 0;

  always #5 clk = ~clk;

  sha3_round_controller #(.NUM_ROUNDS(NR), .ROUNDS_PER_CYCLE(1)) u_dut (
    .clk_i(clk), .rst_i(rst),
`ifdef SHA3_ROUND_CE_EN
    .ce_i(ce),
`endif
    .block_valid_i(block_valid), .block_last_i(block_last), .block_ready_o(block_ready),
    .absorb_en_o(absorb_en), .state_clr_o(state_clr), .round_en_o(round_en),
    .round_idx_o(round_idx), .round_last_o(round_last), .hash_valid_o(hash_valid),
    .hash_ready_i(hash_ready), .busy_o(busy)
  );

  sha3_round_controller #(.NUM_ROUNDS(NR), .ROUNDS_PER_CYCLE(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst),
`ifdef SHA3_ROUND_CE_EN
    .ce_i(ce),
`endif
    .block_valid_i(block_valid), .block_last_i(block_last), .block_ready_o(ready4),
    .absorb_en_o(absorb4), .state_clr_o(clr4), .round_en_o(ren4),
    .round_idx_o(idx4), .round_last_o(rlast4), .hash_valid_o(hv4),
    .hash_ready_i(hash_ready), .busy_o(busy4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each round cycle consumes one expected index; each digest handshake one message.
  always @(negedge clk) begin
    rnd_t e;
    if (!rst && round_en) begin
      chk("rnd_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rnd_idx", 32'(round_idx), 32'(e.idx));
        chk("rnd_last", 32'(round_last), 32'(e.last));
      end
    end
    if (!rst && hash_valid && hash_ready) begin
      chk("hash_pending", 32'(hash_q.size() != 0), 32'd1);
      if (hash_q.size() != 0) begin
        void'(hash_q.pop_front());
      end
      chk("hash_rounds_done", 32'(exp_q.size()), 32'd0);
    end
  end

  task automatic send_block(input logic last, input logic exp_clr, input string tag);
    block_valid = 1'b1;
    block_last  = last;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(block_ready), 32'd1);
    chk({tag, "_absorb"}, 32'(absorb_en), 32'd1);
    chk({tag, "_clr"}, 32'(state_clr), 32'(exp_clr));
    chk({tag, "_nohash"}, 32'(hash_valid), 32'd0);
    for (int k = 0; k < NR; k++) begin
      exp_q.push_back('{idx: 5'(k), last: (k == NR - 1)});
    end
    if (last) begin
      msg_id++;
      hash_q.push_back(msg_id);
    end
    tick();
    block_valid = 1'b0;
    block_last  = 1'b0;
  endtask

  task automatic run_rounds(input string tag);
    for (int k = 1; k <= NR; k++) begin
      @(negedge clk);
      chk({tag, "_ren"}, 32'(round_en), 32'd1);
      chk({tag, "_busy_ready"}, {30'd0, busy, block_ready}, 32'd2);
      chk({tag, "_rlast"}, 32'(round_last), 32'(k == NR));
      tick();
    end
  endtask

  initial begin
    // Reset: nothing accepted even with a block offered.
    block_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_ready", 32'(block_ready), 32'd0);
      chk("rst_absorb", 32'(absorb_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      tick();
    end
    rst = 1'b0;
    block_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(block_ready), 32'd1);
    chk("post_rst_idx", 32'(round_idx), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_hv", 32'(hash_valid), 32'd0);
    tick();

    // Single-block message; the RPC=4 instance runs alongside.
    hash_ready = 1'b1;
    send_block(1'b1, 1'b1, "m1");
    for (int k = 1; k <= NR; k++) begin
      @(negedge clk);
      chk("m1_ren", 32'(round_en), 32'd1);
      chk("m1_ready", 32'(block_ready), 32'd0);
      chk("m1_rlast", 32'(round_last), 32'(k == NR));
      if (k <= 6) begin
        chk("r4_ren", 32'(ren4), 32'd1);
        chk("r4_idx", 32'(idx4), 32'((k - 1) * 4));
        chk("r4_last", 32'(rlast4), 32'(k == 6));
      end else if (k == 7) begin
        chk("r4_hv", 32'(hv4), 32'd1);
        chk("r4_ren_off", 32'(ren4), 32'd0);
      end else if (k == 8) begin
        chk("r4_idle", 32'(busy4), 32'd0);
      end
      tick();
    end
    @(negedge clk);
    chk("m1_hv", 32'(hash_valid), 32'd1);
    chk("m1_hv_ready", 32'(block_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("m1_idle", {30'd0, busy, block_ready}, 32'd1);
    chk("m1_hv_off", 32'(hash_valid), 32'd0);
    tick();

    // Two-block message: second absorb continues the state.
    send_block(1'b0, 1'b1, "m2a");
    run_rounds("m2a");
    send_block(1'b1, 1'b0, "m2b");
    run_rounds("m2b");
    @(negedge clk);
    chk("m2_hv", 32'(hash_valid), 32'd1);
    tick();

    // Stalled squeeze with upstream pushing a block.
    hash_ready = 1'b0;
    send_block(1'b1, 1'b1, "m3");
    run_rounds("m3");
    block_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("m3_hv_hold", 32'(hash_valid), 32'd1);
      chk("m3_no_ready", 32'(block_ready), 32'd0);
      chk("m3_no_absorb", 32'(absorb_en), 32'd0);
      tick();
    end
    block_valid = 1'b0;
    hash_ready = 1'b1;
    @(negedge clk);
    chk("m3_hv_hs", 32'(hash_valid), 32'd1);
    tick();
    hash_ready = 1'b0;

    // Reset in the middle of a permutation.
    send_block(1'b1, 1'b1, "m4");
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk("m4_ren", 32'(round_en), 32'd1);
      tick();
    end
    chk("m4_idx7", 32'(round_idx), 32'd7);
    rst = 1'b1;
    @(negedge clk);
    chk("m4_rst_ren", 32'(round_en), 32'd0);
    chk("m4_rst_busy_ready", {30'd0, busy, block_ready}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("m4_after_idle", {30'd0, busy, block_ready}, 32'd1);
    chk("m4_after_idx", 32'(round_idx), 32'd0);
    chk("m4_after_hv", 32'(hash_valid), 32'd0);
    tick();
    exp_q.delete();
    hash_q.delete();
    msg_id = 0;
    hash_ready = 1'b1;
    send_block(1'b1, 1'b1, "m5");
    run_rounds("m5");
    @(negedge clk);
    chk("m5_hv", 32'(hash_valid), 32'd1);
    tick();

`ifdef SHA3_ROUND_CE_EN
    // Clock-enable stall at round 12 delays completion by the stall length.
    send_block(1'b1, 1'b1, "mce");
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("mce_ren", 32'(round_en), 32'd1);
      tick();
    end
    ce = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mce_stall_ren", 32'(round_en), 32'd0);
      chk("mce_stall_idx", 32'(round_idx), 32'd12);
      tick();
    end
    ce = 1'b1;
    for (int k = 13; k <= NR; k++) begin
      @(negedge clk);
      chk("mce_ren2", 32'(round_en), 32'd1);
      chk("mce_rlast", 32'(round_last), 32'(k == NR));
      tick();
    end
    @(negedge clk);
    chk("mce_hv", 32'(hash_valid), 32'd1);
    tick();
`endif

    @(negedge clk);
    chk("final_idle", {30'd0, busy, block_ready}, 32'd1);
    chk("final_rounds_left", 32'(exp_q.size()), 32'd0);
    chk("final_hash_left", 32'(hash_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
